resets_ctl: RTL and testbench



---
 rtl/resets_ctl.sv | 173 +++++++++++++++++
 tb/tb_resets_ctl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/resets_ctl.sv
// Reset controller: filters the external reset pin and classifies each assertion as long, special (PC clear) or glitch.
// Build option: define RESET_SYNC_EN to pass reset_in through a SYNC_STAGES-deep synchroniser (default: single input register).
module resets_ctl #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LONG    = 3,
    parameter int STRETCH     = 4
) (
    input  logic       clk,
    input  logic       fpga_reset,
    input  logic       reset_in,
    input  logic       M1,
    input  logic       T2,
    output logic       nreset,
    output logic       clrpc,
    output logic       busy,
    output logic [1:0] last_cause
);

    localparam int MaxCnt = (MIN_LONG > STRETCH) ? MIN_LONG : STRETCH;
    localparam int CW     = $clog2(MaxCnt + 1);
    localparam logic [CW-1:0] MinLongC = CW'(MIN_LONG);
    localparam logic [CW-1:0] StretchC = CW'(STRETCH);
    localparam logic [CW-1:0] OneC     = CW'(1);

    if (SYNC_STAGES < 2 || MIN_LONG < 2 || STRETCH < 1) begin : g_bad_param
        $error("resets_ctl: SYNC_STAGES>=2, MIN_LONG>=2 and STRETCH>=1 are required");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LONG,
        S_STRETCH,
        S_SPECIAL
    } state_t;

    logic rs;

`ifdef RESET_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], reset_in};
        end
    end

    assign rs = sync_q[SYNC_STAGES-1];
`else
    logic rs_q;

    always_ff @(posedge clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            rs_q <= 1'b0;
        end else begin
            rs_q <= reset_in;
        end
    end

    assign rs = rs_q;
`endif

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cntInc_d;
    logic [CW-1:0] cntDec_d;
    logic          nreset_q;
    logic          clrpc_q;
    logic          busy_q;
    logic [1:0]    lastCause_q;
    logic          m1AtStart_q;
    logic          fromSpecial_q;
    logic          waitLow_q;
    logic          m1t2;

    assign m1t2     = M1 & T2;
    assign cntInc_d = (cnt_q == '1) ? cnt_q : cnt_q + OneC;
    assign cntDec_d = (cnt_q == '0) ? cnt_q : cnt_q - OneC;

    // waitLow_q holds off the clrpc release until M1&T2 has been seen low inside SPECIAL,
    // so a pulse already present on entry cannot end the special reset.
    always_ff @(posedge clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            state_q       <= S_STRETCH;
            cnt_q         <= StretchC;
            nreset_q      <= 1'b0;
            clrpc_q       <= 1'b0;
            busy_q        <= 1'b1;
            lastCause_q   <= 2'b11;
            m1AtStart_q   <= 1'b0;
            fromSpecial_q <= 1'b0;
            waitLow_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rs) begin
                        state_q       <= S_COUNT;
                        cnt_q         <= OneC;
                        m1AtStart_q   <= M1;
                        fromSpecial_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (rs) begin
                        cnt_q <= cntInc_d;
                        if (cntInc_d == MinLongC) begin
                            state_q     <= S_LONG;
                            nreset_q    <= 1'b0;
                            clrpc_q     <= 1'b0;
                            lastCause_q <= 2'b10;
                        end
                    end else if (m1AtStart_q || fromSpecial_q) begin
                        // A glitch interrupting SPECIAL falls back into SPECIAL with clrpc kept high.
                        state_q   <= S_SPECIAL;
                        clrpc_q   <= 1'b1;
                        nreset_q  <= 1'b1;
                        waitLow_q <= 1'b1;
                        if (m1AtStart_q) begin
                            lastCause_q <= 2'b01;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_LONG: begin
                    if (!rs) begin
                        state_q <= S_STRETCH;
                        cnt_q   <= StretchC;
                    end
                end
                S_STRETCH: begin
                    if (rs) begin
                        state_q <= S_LONG;
                    end else if (cnt_q == OneC) begin
                        state_q  <= S_IDLE;
                        nreset_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cntDec_d;
                    end
                end
                S_SPECIAL: begin
                    if (rs) begin
                        state_q       <= S_COUNT;
                        cnt_q         <= OneC;
                        m1AtStart_q   <= M1;
                        fromSpecial_q <= 1'b1;
                    end else if (!waitLow_q && m1t2) begin
                        state_q <= S_IDLE;
                        clrpc_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!m1t2) begin
                        waitLow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nreset     = nreset_q;
    assign clrpc      = clrpc_q;
    assign busy       = busy_q;
    assign last_cause = lastCause_q;

endmodule

// File: tb/tb_resets_ctl.sv
// Directed self-checking bench for resets_ctl; expected timings are written relative to the input latency L.
module tb_resets_ctl;

`ifdef RESET_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       clk;
    logic       fpga_reset;
    logic       reset_in;
    logic       M1;
    logic       T2;
    logic       nreset;
    logic       clrpc;
    logic       busy;
    logic [1:0] last_cause;

    int checks = 0;
    int errors = 0;

    resets_ctl dut (
        .clk        (clk),
        .fpga_reset (fpga_reset),
        .reset_in   (reset_in),
        .M1         (M1),
        .T2         (T2),
        .nreset     (nreset),
        .clrpc      (clrpc),
        .busy       (busy),
        .last_cause (last_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic m1, input logic t2);
        reset_in = r;
        M1       = m1;
        T2       = t2;
    endtask

    task automatic checkOutput(input string tag, input int k, input logic expN, input logic expC,
                               input logic expB, input logic [1:0] expCause);
        checks++;
        assert (nreset === expN) else begin
            errors++;
            $error("FAIL %s k=%0d nreset observed=%b expected=%b", tag, k, nreset, expN);
        end
        checks++;
        assert (clrpc === expC) else begin
            errors++;
            $error("FAIL %s k=%0d clrpc observed=%b expected=%b", tag, k, clrpc, expC);
        end
        checks++;
        assert (busy === expB) else begin
            errors++;
            $error("FAIL %s k=%0d busy observed=%b expected=%b", tag, k, busy, expB);
        end
        checks++;
        assert (last_cause === expCause) else begin
            errors++;
            $error("FAIL %s k=%0d last_cause observed=%b expected=%b", tag, k, last_cause, expCause);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fpga_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("por_active", 0, 1'b0, 1'b0, 1'b1, 2'b11);
        step();
        step();
        checkOutput("por_held", 0, 1'b0, 1'b0, 1'b1, 2'b11);
        fpga_reset = 1'b0;

        $display("[TB] power-on release");
        for (int k = 1; k <= 5; k++) begin
            step();
            checkOutput("por", k, (k >= 4), 1'b0, (k < 4), 2'b11);
        end

        $display("[TB] long reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= L + 9; k++) begin
            step();
            checkOutput("long", k, !(k >= L + 3 && k <= L + 7), 1'b0,
                        (k >= L + 1 && k <= L + 7), (k >= L + 3) ? 2'b10 : 2'b11);
            if (k == 3) reset_in = 1'b0;
        end

        $display("[TB] glitch");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= L + 4; k++) begin
            step();
            checkOutput("glitch", k, 1'b1, 1'b0, (k >= L + 1 && k <= L + 2), 2'b10);
            if (k == 2) reset_in = 1'b0;
        end

        $display("[TB] special reset");
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= L + 7; k++) begin
            step();
            checkOutput("special", k, 1'b1, (k >= L + 2 && k <= L + 5),
                        (k >= L + 1 && k <= L + 5), (k >= L + 2) ? 2'b01 : 2'b10);
            if (k == 1) reset_in = 1'b0;
            if (k == L + 4) T2 = 1'b0;
            if (k == L + 5) T2 = 1'b1;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] re-assert during stretch");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= L + 13; k++) begin
            step();
            checkOutput("restretch", k, !(k >= L + 3 && k <= L + 11), 1'b0,
                        (k >= L + 1 && k <= L + 11), (k >= L + 3) ? 2'b10 : 2'b01);
            if (k == 3) reset_in = 1'b0;
            if (k == 5) reset_in = 1'b1;
            if (k == 7) reset_in = 1'b0;
        end

        $display("[TB] special then long");
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= L + 15; k++) begin
            step();
            checkOutput("spec_long", k, !(k >= L + 7 && k <= L + 13), (k >= L + 2 && k <= L + 6),
                        (k >= L + 1 && k <= L + 13),
                        (k >= L + 7) ? 2'b10 : ((k >= L + 2) ? 2'b01 : 2'b10));
            if (k == 1) reset_in = 1'b0;
            if (k == 4) reset_in = 1'b1;
            if (k == 9) reset_in = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] power-on reset mid-operation");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= L + 2; k++) begin
            step();
        end
        checkOutput("mid_counting", 0, 1'b1, 1'b0, 1'b1, 2'b10);
        fpga_reset = 1'b1;
        reset_in   = 1'b0;
        #1;
        checkOutput("mid_por", 0, 1'b0, 1'b0, 1'b1, 2'b11);
        step();
        fpga_reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checkOutput("mid_por_rel", k, (k >= 4), 1'b0, (k < 4), 2'b11);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
